// File: rtl/onehot5_tx_if.sv
// Handshake and line-word bundle for the 1-of-5 symbol transmitter.
// The producer side uses the master modport, the transmitter uses slave.
interface onehot5_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_idx;
    logic [4:0] y;
    logic       y_valid;
    logic       err;

    modport master (
        output in_valid,
        output in_idx,
        input  in_ready,
        input  y,
        input  y_valid,
        input  err
    );

    modport slave (
        input  in_valid,
        input  in_idx,
        output in_ready,
        output y,
        output y_valid,
        output err
    );
endinterface

// File: rtl/onehot5_tx.sv
// One-hot (1-of-5) symbol transmitter: each accepted index is driven on y for
// HOLD cycles, followed by GAP all-zero spacer cycles before the next accept.
module onehot5_tx #(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic         clk,
    input  logic         rst,
    onehot5_tx_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        SPACE = 2'd2
    } state_e;

    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
    localparam logic [7:0] GAP_M1  = 8'(GAP - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [4:0] y_q,     y_d;
    logic       y_valid_q, y_valid_d;
    logic       err_q,   err_d;

    // Next-state, counter and output-register decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_idx <= 3'd4) begin
                        y_d       = 5'b00001 << bus.in_idx;
                        y_valid_d = 1'b1;
                        state_d   = SEND;
                        cnt_d     = HOLD_M1;
                    end else begin
                        err_d     = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (cnt_q == 8'd0) begin
                    y_d       = 5'b00000;
                    y_valid_d = 1'b0;
                    // With no spacer the symbol ends straight back in IDLE.
                    if (GAP == 0) begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = SPACE;
                        cnt_d   = GAP_M1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SPACE: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = 8'd0;
                y_d       = 5'b00000;
                y_valid_d = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs; reset wins over any accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            y_q       <= 5'b00000;
            y_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            err_q     <= err_d;
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.y        = y_q;
    assign bus.y_valid  = y_valid_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_onehot5_tx.sv
// Bench for onehot5_tx: two instances (HOLD=4/GAP=1 and HOLD=1/GAP=0) share one
// stimulus stream and are checked every cycle against a timeline model.
module tb_onehot5_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_idx = 3'd0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit started = 1'b0;

    onehot5_tx_if if0 ();
    onehot5_tx_if if1 ();

    assign if0.in_valid = in_valid;
    assign if0.in_idx   = in_idx;
    assign if1.in_valid = in_valid;
    assign if1.in_idx   = in_idx;

    onehot5_tx #(.HOLD(4), .GAP(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    onehot5_tx #(.HOLD(1), .GAP(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    logic [4:0] y_a   [2];
    logic       yv_a  [2];
    logic       rdy_a [2];
    logic       err_a [2];

    assign y_a[0]   = if0.y;
    assign yv_a[0]  = if0.y_valid;
    assign rdy_a[0] = if0.in_ready;
    assign err_a[0] = if0.err;
    assign y_a[1]   = if1.y;
    assign yv_a[1]  = if1.y_valid;
    assign rdy_a[1] = if1.in_ready;
    assign err_a[1] = if1.err;

    always #5 clk = ~clk;

    // Timeline model: last legal accept cycle/index and last illegal accept cycle.
    int hold_p [2] = '{4, 1};
    int gap_p  [2] = '{1, 0};
    int acc_cyc [2] = '{-1000, -1000};
    int acc_idx [2] = '{0, 0};
    int ill_cyc [2] = '{-1000, -1000};
    int legal_cnt [2] = '{0, 0};
    int illegal_cnt [2] = '{0, 0};
    int rise_cnt [2] = '{0, 0};
    int errp_cnt [2] = '{0, 0};
    logic yv_prev [2] = '{1'b0, 1'b0};

    function automatic bit exp_ready(int k, int c);
        return !(c > acc_cyc[k] && c <= acc_cyc[k] + hold_p[k] + gap_p[k]);
    endfunction

    function automatic logic [4:0] exp_y(int k, int c);
        logic [4:0] one;
        one = 5'b00001;
        if (c >= acc_cyc[k] + 1 && c <= acc_cyc[k] + hold_p[k])
            return one << acc_idx[k];
        return 5'b00000;
    endfunction

    function automatic bit exp_err(int k, int c);
        return (c == ill_cyc[k] + 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Advance the model on each edge using the inputs of the ending cycle.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                acc_cyc[k] = -1000;
                ill_cyc[k] = -1000;
            end else if (in_valid && exp_ready(k, cyc)) begin
                if (in_idx <= 3'd4) begin
                    acc_cyc[k] = cyc;
                    acc_idx[k] = int'(in_idx);
                    legal_cnt[k]++;
                end else begin
                    ill_cyc[k] = cyc;
                    illegal_cnt[k]++;
                end
            end
        end
        if (rst) started = 1'b1;
        cyc++;
    end

    // Per-cycle comparison against the model plus structural invariants.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("y[%0d]", k), 32'(y_a[k]), 32'(exp_y(k, cyc)));
                chk($sformatf("y_valid[%0d]", k), 32'(yv_a[k]), 32'(exp_y(k, cyc) != 5'd0));
                chk($sformatf("in_ready[%0d]", k), 32'(rdy_a[k]), 32'(exp_ready(k, cyc)));
                chk($sformatf("err[%0d]", k), 32'(err_a[k]), 32'(exp_err(k, cyc)));
                chk($sformatf("onehot[%0d]", k), 32'($countones(y_a[k]) <= 1), 32'd1);
                chk($sformatf("yv_or[%0d]", k), 32'(yv_a[k]), 32'(|y_a[k]));
                chk($sformatf("err_rise[%0d]", k), 32'(err_a[k] && yv_a[k] && !yv_prev[k]), 32'd0);
                if (yv_a[k] === 1'b1 && yv_prev[k] !== 1'b1) rise_cnt[k]++;
                if (err_a[k] === 1'b1) errp_cnt[k]++;
                yv_prev[k] = yv_a[k];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int last_t;
        int n;
        logic [4:0] one;
        one = 5'b00001;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_y0", 32'(if0.y), 32'd0);
        chk("rst_rdy0", 32'(if0.in_ready), 32'd1);
        chk("rst_err0", 32'(if0.err), 32'd0);

        // Single symbol idx=2: four cycles of 00100, one spacer, then ready.
        in_valid = 1'b1;
        in_idx   = 3'd2;
        step();
        in_valid = 1'b0;
        chk("h1_y", 32'(if1.y), 32'h04);
        for (int i = 0; i < 4; i++) begin
            chk("sym2_y", 32'(if0.y), 32'h04);
            chk("sym2_yv", 32'(if0.y_valid), 32'd1);
            if (i == 0) chk("h1_next_rdy", 32'(if1.in_ready), 32'd0);
            step();
        end
        chk("space_y", 32'(if0.y), 32'd0);
        chk("space_rdy", 32'(if0.in_ready), 32'd0);
        step();
        chk("idle_rdy", 32'(if0.in_ready), 32'd1);

        // Illegal index followed immediately by a legal one.
        in_valid = 1'b1;
        in_idx   = 3'd6;
        step();
        chk("ill_err", 32'(if0.err), 32'd1);
        chk("ill_y", 32'(if0.y), 32'd0);
        chk("ill_rdy", 32'(if0.in_ready), 32'd1);
        in_idx = 3'd1;
        step();
        chk("ill_err_clr", 32'(if0.err), 32'd0);
        chk("after_ill_y", 32'(if0.y), 32'h02);
        in_valid = 1'b0;
        repeat (8) step();

        // Reset in the second SEND cycle of idx=3 aborts the symbol.
        in_valid = 1'b1;
        in_idx   = 3'd3;
        step();
        in_valid = 1'b0;
        step();
        chk("send2_y", 32'(if0.y), 32'h08);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_y", 32'(if0.y), 32'd0);
        chk("abort_yv", 32'(if0.y_valid), 32'd0);
        chk("abort_rdy", 32'(if0.in_ready), 32'd1);
        in_valid = 1'b1;
        in_idx   = 3'd0;
        step();
        chk("post_rst_y", 32'(if0.y), 32'h01);
        in_valid = 1'b0;
        repeat (8) step();

        // Back-to-back 0..4 with in_valid held: accepts every HOLD+GAP+1 cycles.
        last_t = 0;
        in_valid = 1'b1;
        for (int s = 0; s < 5; s++) begin
            in_idx = 3'(s);
            n = 0;
            while (!if0.in_ready && n < 50) begin
                step();
                n++;
            end
            chk("b2b_wait", 32'(n < 50), 32'd1);
            if (s > 0) chk("b2b_period", 32'(cyc - last_t), 32'd6);
            last_t = cyc;
            step();
            chk("b2b_y", 32'(if0.y), 32'(one << s));
        end
        in_valid = 1'b0;
        repeat (8) step();

        // HOLD=1, GAP=0 instance: idx=4 every other cycle.
        in_valid = 1'b1;
        in_idx   = 3'd4;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("alt_y", 32'(if1.y), (i % 2 == 0) ? 32'h10 : 32'h00);
            chk("alt_rdy", 32'(if1.in_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        repeat (4) step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 10000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_idx   = 3'($urandom_range(0, 7));
            rst      = ($urandom_range(0, 199) == 0);
            step();
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        repeat (20) step();
        @(negedge clk);
        #1;

        for (int k = 0; k < 2; k++) begin
            chk($sformatf("legal_vs_rise[%0d]", k), 32'(rise_cnt[k]), 32'(legal_cnt[k]));
            chk($sformatf("illegal_vs_err[%0d]", k), 32'(errp_cnt[k]), 32'(illegal_cnt[k]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
